pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Decides every cycle whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) holds, loads, or loads a bubble.
- Covers three cases: data-memory wait (handshake with a multi-cycle timeout FSM), EX-stage control redirect, and load-use hazard.
- Also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller and the decode
// logic that feeds it: FSM encoding, default sizing, and the select codes
// that identify loads and sequential next-PC.
package pipe_ctrl_pkg;

    // FSM state encoding, also exposed on the state output.
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    typedef enum logic [1:0] {
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT,
        S_ERROR    = ST_ERROR
    } state_e;

    // Default sizing.
    localparam int DEF_MAX_WAIT = 16;
    localparam int DEF_CNT_W    = 32;

    // WDSel value that selects data memory as the writeback source (a load).
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    // NPCOp value for sequential PC+4; anything else is a redirect.
    localparam logic [1:0] NPCOP_SEQ = 2'b00;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count up on request, holding once the counter is full.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Decides each
// cycle whether every pipeline register holds, loads, or loads a bubble,
// handling data-memory waits (with timeout FSM), EX redirects and load-use
// hazards, and keeps saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only has to reach MAX_WAIT-1.
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic mem_busy;
    logic load_use;

    assign mem_busy = mem_req & ~dmem_ready;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 never carries a real dependency.
    assign load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    // Zero-latency pipeline controls, highest-priority condition first.
    // NOTE: every output gets a default before the if-chain so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_flush = 1'b0;
        if ((state_q == S_ERROR) || mem_busy) begin
            // Freeze everything up to MEM; redirect/load-use re-present later.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // Squash the two younger instructions; PC loads the target.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID one cycle and insert a bubble behind the load.
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // Memory-wait FSM next state, wait counter and sticky timeout flag.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                // Ready, or the request dropping, both end the wait.
                if (!mem_busy) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_ERROR: begin
                // Absorbing until reset.
                timeout_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (pc_stall),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (ifid_flush),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl, built with MAX_WAIT=4 and CNT_W=3
// so timeout and counter saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;

    // Control vector: {pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                  idex_flush, exmem_stall, memwb_flush}
    localparam logic [6:0] CTL_NONE   = 7'b0000000;
    localparam logic [6:0] CTL_FREEZE = 7'b1101011;
    localparam logic [6:0] CTL_REDIR  = 7'b0010100;
    localparam logic [6:0] CTL_LU     = 7'b1100100;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
    logic             mem_req, dmem_ready;
    logic             pc_stall, ifid_stall, ifid_flush, idex_stall;
    logic             idex_flush, exmem_stall, memwb_flush, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctl;

    int checks = 0;
    int passed = 0;

    assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                  idex_flush, exmem_stall, memwb_flush};

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_stall  (idex_stall),
        .idex_flush  (idex_flush),
        .exmem_stall (exmem_stall),
        .memwb_flush (memwb_flush),
        .mem_timeout (mem_timeout),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use;
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
        checks++; if (mem_timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", mem_timeout); else passed++;
        checks++; if (stall_cnt !== 3'd0) $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); else passed++;
        checks++; if (flush_cnt !== 3'd0) $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt); else passed++;
        checks++; if (ctl !== CTL_NONE) $display("FAIL rst_ctl: got %b want %b", ctl, CTL_NONE); else passed++;
        // Controls stay combinational from RUN even while reset is held.
        set_load_use();
        #1;
        checks++; if (ctl !== CTL_LU) $display("FAIL rst_ctl_lu: got %b want %b", ctl, CTL_LU); else passed++;
        step();
        checks++; if (stall_cnt !== 3'd0) $display("FAIL rst_cnt_held: got %0d want 0", stall_cnt); else passed++;
        clear_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_use;
        do_reset();
        set_load_use();
        #1;
        checks++; if (ctl !== CTL_LU) $display("FAIL lu_ctl: got %b want %b", ctl, CTL_LU); else passed++;
        step();
        // Load advanced to MEM; a bubble now sits in EX.
        ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        checks++; if (ctl !== CTL_NONE) $display("FAIL lu_one_cycle: got %b want %b", ctl, CTL_NONE); else passed++;
        checks++; if (stall_cnt !== 3'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else passed++;
        // Load to x0 never stalls.
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        checks++; if (ctl !== CTL_NONE) $display("FAIL lu_x0: got %b want %b", ctl, CTL_NONE); else passed++;
        // Match through rs2.
        ex_rd = 5'd7; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        checks++; if (ctl !== CTL_LU) $display("FAIL lu_rs2: got %b want %b", ctl, CTL_LU); else passed++;
        // rs2 matches but is not read.
        id_use_rs2 = 1'b0;
        #1;
        checks++; if (ctl !== CTL_NONE) $display("FAIL lu_rs2_unused: got %b want %b", ctl, CTL_NONE); else passed++;
        // Non-load producer needs no stall.
        id_use_rs2 = 1'b1; ex_is_load = 1'b0;
        #1;
        checks++; if (ctl !== CTL_NONE) $display("FAIL lu_not_load: got %b want %b", ctl, CTL_NONE); else passed++;
        step();
        checks++; if (stall_cnt !== 3'd1) $display("FAIL lu_stall_cnt_end: got %0d want 1", stall_cnt); else passed++;
        clear_inputs();
    endtask

    task automatic test_redirect;
        do_reset();
        set_load_use();
        ex_redirect = 1'b1;
        #1;
        checks++; if (ctl !== CTL_REDIR) $display("FAIL redir_ctl: got %b want %b", ctl, CTL_REDIR); else passed++;
        step();
        clear_inputs();
        #1;
        checks++; if (flush_cnt !== 3'd1) $display("FAIL redir_flush_cnt: got %0d want 1", flush_cnt); else passed++;
        checks++; if (stall_cnt !== 3'd0) $display("FAIL redir_stall_cnt: got %0d want 0", stall_cnt); else passed++;
        checks++; if (ctl !== CTL_NONE) $display("FAIL redir_after: got %b want %b", ctl, CTL_NONE); else passed++;
    endtask

    task automatic test_mem_wait;
        logic [1:0] exp_state;
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ex_redirect = 1'b1;
            exp_state = (i == 0) ? 2'd0 : 2'd1;
            #1;
            checks++; if (ctl !== CTL_FREEZE) $display("FAIL wait_ctl[%0d]: got %b want %b", i, ctl, CTL_FREEZE); else passed++;
            checks++; if (state !== exp_state) $display("FAIL wait_state[%0d]: got %0d want %0d", i, state, exp_state); else passed++;
            step();
        end
        checks++; if (state !== 2'd1) $display("FAIL wait_state_held: got %0d want 1", state); else passed++;
        // Memory completes; the pending redirect now takes effect.
        dmem_ready = 1'b1;
        #1;
        checks++; if (ctl !== CTL_REDIR) $display("FAIL wait_done_ctl: got %b want %b", ctl, CTL_REDIR); else passed++;
        step();
        clear_inputs();
        #1;
        checks++; if (state !== 2'd0) $display("FAIL wait_back_run: got %0d want 0", state); else passed++;
        checks++; if (stall_cnt !== 3'd3) $display("FAIL wait_stall_cnt: got %0d want 3", stall_cnt); else passed++;
        checks++; if (flush_cnt !== 3'd1) $display("FAIL wait_flush_cnt: got %0d want 1", flush_cnt); else passed++;
    endtask

    task automatic test_timeout;
        logic [1:0] exp_state;
        logic       exp_to;
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_state = (i < 3) ? 2'd1 : 2'd2;
            exp_to    = (i == 3);
            checks++; if (state !== exp_state) $display("FAIL to_state[%0d]: got %0d want %0d", i, state, exp_state); else passed++;
            checks++; if (mem_timeout !== exp_to) $display("FAIL to_flag[%0d]: got %b want %b", i, mem_timeout, exp_to); else passed++;
        end
        // Request drops, but ERROR keeps the pipeline frozen.
        mem_req = 1'b0;
        #1;
        checks++; if (ctl !== CTL_FREEZE) $display("FAIL to_frozen: got %b want %b", ctl, CTL_FREEZE); else passed++;
        step();
        checks++; if (state !== 2'd2) $display("FAIL to_absorb: got %0d want 2", state); else passed++;
        checks++; if (mem_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", mem_timeout); else passed++;
        checks++; if (stall_cnt !== 3'd5) $display("FAIL to_stall_cnt: got %0d want 5", stall_cnt); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL to_rst_state: got %0d want 0", state); else passed++;
        checks++; if (mem_timeout !== 1'b0) $display("FAIL to_rst_flag: got %b want 0", mem_timeout); else passed++;
        checks++; if (stall_cnt !== 3'd0) $display("FAIL to_rst_stall_cnt: got %0d want 0", stall_cnt); else passed++;
        checks++; if (ctl !== CTL_NONE) $display("FAIL to_rst_ctl: got %b want %b", ctl, CTL_NONE); else passed++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_saturation;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        set_load_use();
        for (int i = 0; i < 10; i++) begin
            step();
            exp_cnt = (i + 1 > 7) ? 3'd7 : CNT_W'(i + 1);
            checks++; if (stall_cnt !== exp_cnt) $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        step();
        step();
        checks++; if (state !== 2'd1) $display("FAIL ar_in_wait: got %0d want 1", state); else passed++;
        checks++; if (stall_cnt !== 3'd2) $display("FAIL ar_cnt_before: got %0d want 2", stall_cnt); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL ar_state: got %0d want 0", state); else passed++;
        checks++; if (stall_cnt !== 3'd0) $display("FAIL ar_stall_cnt: got %0d want 0", stall_cnt); else passed++;
        checks++; if (mem_timeout !== 1'b0) $display("FAIL ar_flag: got %b want 0", mem_timeout); else passed++;
        mem_req = 1'b0;
        #1;
        checks++; if (ctl !== CTL_NONE) $display("FAIL ar_ctl: got %b want %b", ctl, CTL_NONE); else passed++;
        rst = 1'b1;
        step();
        checks++; if (state !== 2'd0) $display("FAIL ar_after: got %0d want 0", state); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
